// File: rtl/fifo_stream_reader_pkg.sv
// Shared types and defaults for the FIFO-to-stream reader.
package fifo_stream_reader_pkg;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } occ_t;

    localparam int DW_DEF      = 8;
    localparam int PKT_LEN_DEF = 16;

endpackage

// File: rtl/fifo_stream_reader_stream_skid_buf.sv
// Two-entry head/skid output buffer: absorbs data returning from the FIFO and presents it as a valid/ready stream.
//   state | meaning
//   EMPTY | nothing buffered, m_valid low
//   ONE   | head holds the next beat
//   TWO   | head and skid both hold beats, skid is the younger one
module stream_skid_buf
    import fifo_stream_reader_pkg::*;
#(
    parameter int DW = DW_DEF
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          wr,
    input  logic [DW-1:0] wr_data,
    input  logic          m_ready,
    output logic          m_valid,
    output logic [DW-1:0] m_data,
    output logic          pop,
    output occ_t          occ
);

    occ_t          occ_q, occ_d;
    logic [DW-1:0] head_q, head_d;
    logic [DW-1:0] skid_q, skid_d;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            occ_q  <= EMPTY;
            head_q <= '0;
            skid_q <= '0;
        end else begin
            occ_q  <= occ_d;
            head_q <= head_d;
            skid_q <= skid_d;
        end
    end

    always_comb begin
        occ_d  = occ_q;
        head_d = head_q;
        skid_d = skid_q;
        pop    = (occ_q != EMPTY) & m_ready;
        case (occ_q)
            EMPTY: begin
                if (wr) begin
                    head_d = wr_data;
                    occ_d  = ONE;
                end
            end
            ONE: begin
                case ({wr, pop})
                    2'b10: begin
                        skid_d = wr_data;
                        occ_d  = TWO;
                    end
                    2'b01: occ_d = EMPTY;
                    2'b11: head_d = wr_data;
                    default: ;
                endcase
            end
            TWO: begin
                // The read issue logic never lets a write land here without a pop.
                if (pop) begin
                    head_d = skid_q;
                    if (wr) skid_d = wr_data;
                    else    occ_d  = ONE;
                end
            end
            default: occ_d = EMPTY;
        endcase
    end

    assign m_valid = (occ_q != EMPTY);
    assign m_data  = head_q;
    assign occ     = occ_q;

endmodule

// File: rtl/fifo_stream_reader.sv
// Drains a sync FIFO read port into a valid/ready stream at one beat per cycle.
// Build option FIFO_STREAM_READER_PKT_LAST_EN adds the m_last packet marker and its beat counter.
module fifo_stream_reader
    import fifo_stream_reader_pkg::*;
#(
    parameter int DW      = DW_DEF,
    parameter int PKT_LEN = PKT_LEN_DEF
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en,
    input  logic          fifo_empty,
    input  logic [DW-1:0] fifo_data,
    output logic          fifo_rd,
    output logic          m_valid,
    input  logic          m_ready,
    output logic [DW-1:0] m_data,
`ifdef FIFO_STREAM_READER_PKT_LAST_EN
    output logic          m_last,
`endif
    output logic          busy
);

    if (PKT_LEN < 1 || PKT_LEN > 65535) begin : g_bad_pkt_len
        $error("PKT_LEN must be in 1..65535");
    end

    occ_t       occ;
    logic       inflight;
    logic       pop;
    logic [2:0] fill;

    // Occupancy after this edge must stay below two for a new read to fit.
    assign fill    = {1'b0, occ} + {2'b00, inflight};
    assign fifo_rd = rst & en & ~fifo_empty & (fill < (3'd2 + {2'b00, pop}));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) inflight <= 1'b0;
        else      inflight <= fifo_rd;
    end

    stream_skid_buf #(.DW(DW)) u_buf (
        .clk     (clk),
        .rst     (rst),
        .wr      (inflight),
        .wr_data (fifo_data),
        .m_ready (m_ready),
        .m_valid (m_valid),
        .m_data  (m_data),
        .pop     (pop),
        .occ     (occ)
    );

    assign busy = (occ != EMPTY) | inflight;

`ifdef FIFO_STREAM_READER_PKT_LAST_EN
    localparam logic [15:0] LAST_IDX = 16'(PKT_LEN - 1);

    logic [15:0] beat_cnt;

    assign m_last = m_valid & (beat_cnt == LAST_IDX);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            beat_cnt <= '0;
        end else if (pop) begin
            beat_cnt <= m_last ? 16'd0 : beat_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_fifo_stream_reader.sv
// Scoreboard bench for fifo_stream_reader: a FIFO model feeds the DUT, a negedge monitor checks every stream beat.
module tb_fifo_stream_reader;

    localparam int DW      = 8;
    localparam int PKT_LEN = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          en = 1'b0;
    logic          fifo_empty = 1'b1;
    logic [DW-1:0] fifo_data = '0;
    logic          m_ready = 1'b0;
    logic          fifo_rd;
    logic          m_valid;
    logic [DW-1:0] m_data;
    logic          busy;
`ifdef FIFO_STREAM_READER_PKT_LAST_EN
    logic          m_last;
`endif

    fifo_stream_reader #(.DW(DW), .PKT_LEN(PKT_LEN)) dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .fifo_empty (fifo_empty),
        .fifo_data  (fifo_data),
        .fifo_rd    (fifo_rd),
        .m_valid    (m_valid),
        .m_ready    (m_ready),
        .m_data     (m_data),
`ifdef FIFO_STREAM_READER_PKT_LAST_EN
        .m_last     (m_last),
`endif
        .busy       (busy)
    );

    always #5 clk = ~clk;

    int pass_cnt  = 0;
    int total_cnt = 0;
    int cyc       = 0;
    int bad_rd    = 0;

    logic [7:0] fifo_q[$];
    logic [7:0] load_q[$];
    logic [7:0] exp_q[$];
    int         exp_last_q[$];
    int         rd_cyc[$];
    int         pop_cyc[$];
    logic       rd_s = 1'b0;
    logic       force_empty = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: actual %0h expected %0h", name, act, exp);
    endtask

    function automatic int span(input int q[$]);
        return (q.size() == 0) ? -1 : q[q.size()-1] - q[0];
    endfunction

    function automatic int lat(input int a[$], input int b[$]);
        return (a.size() == 0 || b.size() == 0) ? -1 : b[0] - a[0];
    endfunction

    always @(posedge clk) cyc++;

    // Synchronous FIFO model with one-cycle registered read data.
    always @(posedge clk) begin
        if (rd_s && fifo_q.size() != 0) fifo_data <= fifo_q.pop_front();
        while (load_q.size() != 0) fifo_q.push_back(load_q.pop_front());
        fifo_empty <= force_empty || (fifo_q.size() == 0);
    end

    // Monitor: scoreboard pop on each handshake, plus stream-stability checks.
    logic       prev_stall = 1'b0;
    logic [7:0] prev_data  = '0;
    logic       prev_last  = 1'b0;
    always @(negedge clk) begin : mon
        logic [7:0] e;
        int         el;
        rd_s = fifo_rd;
        if (fifo_rd) begin
            rd_cyc.push_back(cyc);
            if (fifo_empty) bad_rd++;
        end
        if (rst && prev_stall) begin
            chk("hold_valid", m_valid, 1);
            chk("hold_data", m_data, prev_data);
`ifdef FIFO_STREAM_READER_PKT_LAST_EN
            chk("hold_last", m_last, prev_last);
`endif
        end
        if (m_valid && m_ready) begin
            pop_cyc.push_back(cyc);
            if (exp_q.size() == 0) begin
                total_cnt++;
                $display("FAIL unexpected_beat: actual %0h expected none", m_data);
            end else begin
                e  = exp_q.pop_front();
                el = exp_last_q.pop_front();
                chk("beat_data", m_data, e);
`ifdef FIFO_STREAM_READER_PKT_LAST_EN
                if (el >= 0) chk("beat_last", m_last, el);
`endif
            end
        end
        prev_stall = rst && m_valid && !m_ready;
        prev_data  = m_data;
`ifdef FIFO_STREAM_READER_PKT_LAST_EN
        prev_last  = m_last;
`endif
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [7:0] b, input int last);
        load_q.push_back(b);
        exp_q.push_back(b);
        exp_last_q.push_back(last);
    endtask

    task automatic clear_log();
        rd_cyc.delete();
        pop_cyc.delete();
    endtask

    task automatic drain(input string name, input int budget);
        int k = 0;
        while ((exp_q.size() != 0 || busy) && k < budget) begin
            step(1);
            k++;
        end
        chk({name, "_left"}, exp_q.size(), 0);
        chk({name, "_busy"}, busy, 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b0; en = 1'b1; m_ready = 1'b1;

        // Reset held with data waiting in the FIFO.
        load(8'hA5, -1);
        step(3);
        chk("rst_fifo_empty", fifo_empty, 0);
        chk("rst_fifo_rd", fifo_rd, 0);
        chk("rst_m_valid", m_valid, 0);
        chk("rst_m_data", m_data, 0);
        chk("rst_busy", busy, 0);
`ifdef FIFO_STREAM_READER_PKT_LAST_EN
        chk("rst_m_last", m_last, 0);
`endif
        clear_log();

        // Single beat.
        @(posedge clk); #1 rst = 1'b1;
        step(6);
        chk("single_rd_count", rd_cyc.size(), 1);
        chk("single_pop_count", pop_cyc.size(), 1);
        chk("single_latency", lat(rd_cyc, pop_cyc), 2);
        chk("single_busy_after", busy, 0);

        // Streaming 0x00..0x07.
        clear_log();
        for (int i = 0; i < 8; i++) load(8'(i), -1);
        step(14);
        chk("stream_rd_count", rd_cyc.size(), 8);
        chk("stream_rd_span", span(rd_cyc), 7);
        chk("stream_pop_count", pop_cyc.size(), 8);
        chk("stream_pop_span", span(pop_cyc), 7);
        chk("stream_latency", lat(rd_cyc, pop_cyc), 2);
        drain("stream", 20);

        // Backpressure.
        clear_log();
        m_ready = 1'b0;
        for (int i = 0; i < 6; i++) load(8'h10 + 8'(i), -1);
        step(8);
        chk("bp_rd_count", rd_cyc.size(), 2);
        chk("bp_valid", m_valid, 1);
        chk("bp_head", m_data, 8'h10);
        pop_cyc.delete();
        m_ready = 1'b1;
        step(12);
        chk("bp_pop_count", pop_cyc.size(), 6);
        chk("bp_pop_span", span(pop_cyc), 5);
        chk("bp_rd_total", rd_cyc.size(), 6);
        drain("bp", 20);

        // Enable dropped after the third read.
        clear_log();
        for (int i = 0; i < 8; i++) load(8'h20 + 8'(i), -1);
        for (int k = 0; k < 40; k++) begin
            step(1);
            if (rd_cyc.size() >= 3) begin
                en = 1'b0;
                break;
            end
        end
        step(10);
        chk("en_rd_count", rd_cyc.size(), 3);
        chk("en_pop_count", pop_cyc.size(), 3);
        chk("en_rd_now", fifo_rd, 0);
        en = 1'b1;
        drain("en", 40);

        // FIFO reports empty mid-stream.
        clear_log();
        for (int i = 0; i < 8; i++) load(8'h40 + 8'(i), -1);
        for (int k = 0; k < 40; k++) begin
            step(1);
            if (rd_cyc.size() >= 2) begin
                force_empty = 1'b1;
                break;
            end
        end
        step(6);
        chk("empty_rd_count", rd_cyc.size(), 3);
        chk("empty_pop_count", pop_cyc.size(), 3);
        force_empty = 1'b0;
        drain("empty", 40);
        chk("empty_pop_total", pop_cyc.size(), 8);

        // Asynchronous reset with two beats buffered.
        m_ready = 1'b0;
        for (int i = 0; i < 4; i++) load(8'h50 + 8'(i), -1);
        step(8);
        chk("rstmid_pre_valid", m_valid, 1);
        chk("rstmid_pre_data", m_data, 8'h50);
        #3 rst = 1'b0;
        #1;
        chk("rstmid_fifo_rd", fifo_rd, 0);
        chk("rstmid_m_valid", m_valid, 0);
        chk("rstmid_m_data", m_data, 0);
        chk("rstmid_busy", busy, 0);
        void'(exp_q.pop_front());
        void'(exp_q.pop_front());
        void'(exp_last_q.pop_front());
        void'(exp_last_q.pop_front());
        step(2);
        rst = 1'b1;
        m_ready = 1'b1;
        drain("rstmid", 20);

        // Packet markers under random backpressure, from a clean reset.
        rst = 1'b0;
        step(2);
        rst = 1'b1;
        step(1);
        for (int i = 0; i < 8; i++) load(8'h30 + 8'(i), (i == 3 || i == 7) ? 1 : 0);
        for (int k = 0; k < 80 && exp_q.size() != 0; k++) begin
            m_ready = 1'($urandom_range(0, 1));
            step(1);
        end
        m_ready = 1'b1;
        drain("pkt", 20);

        chk("no_empty_reads", bad_rd, 0);
        chk("scoreboard_empty", exp_q.size(), 0);
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
